demux_stripe_n: RTL and testbench

//  Parametrised byte-striping demux for the PCIe physical layer TX path; successor to the fixed 2x4 demux.
//  - Distributes a single WIDTH-bit valid-qualified stream round-robin across LANES output lanes.
//  - Presents complete lane-aligned bundles: all lanes update together, with a one-cycle validout pulse.

---
 rtl/demux_stripe_n_pkg.sv | 30 +++
 rtl/demux_stripe_n_if.sv | 17 +
 rtl/demux_stripe_n_stripe_ptr_ctr.sv | 44 ++++
 rtl/demux_stripe_n.sv | 100 ++++++++++
 tb/tb_demux_stripe_n.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/demux_stripe_n_pkg.sv
// Shared constants, types and helpers for the byte-striping demux.
// Optional partial-bundle flush is enabled by defining DEMUX_PARTIAL_FLUSH_EN.
package demux_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_LANES = 4;
  localparam int unsigned MAX_LANES = 64;

  // Pointer width for a given lane count; never narrower than 1 bit.
  function automatic int unsigned ptr_width(input int unsigned lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

  localparam int unsigned PTR_W = ptr_width(DEF_LANES);

  typedef logic [MAX_LANES-1:0] lane_mask_t;

  // Mask with the low 'ptr' bits set: lanes already filled in a partial bundle.
  function automatic lane_mask_t lane_mask(input int unsigned ptr);
    return (lane_mask_t'(1) << ptr) - lane_mask_t'(1);
  endfunction

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_ACCEPT,
    OP_EMIT,
    OP_FLUSH
  } op_e;

endpackage

// File: rtl/demux_stripe_n_if.sv
// Stream-in / lane-bundle-out bus of the byte-striping demux.
// Shared by both builds (DEMUX_PARTIAL_FLUSH_EN only changes demux behaviour).
interface demux_stripe_n_if #(
  parameter int unsigned WIDTH = demux_pkg::DEF_WIDTH,
  parameter int unsigned LANES = demux_pkg::DEF_LANES
);
  localparam int unsigned PW = demux_pkg::ptr_width(LANES);

  logic [WIDTH-1:0]       in;
  logic                   valid;
  logic [LANES*WIDTH-1:0] out;
  logic [LANES-1:0]       validout;
  logic [PW-1:0]          lane_ptr;

  modport master (output in, valid, input out, validout, lane_ptr);
  modport slave  (input in, valid, output out, validout, lane_ptr);
endinterface

// File: rtl/demux_stripe_n_stripe_ptr_ctr.sv
// Mod-LANES lane pointer with a registered last-lane flag.
// Unaffected by DEMUX_PARTIAL_FLUSH_EN apart from the clr input being used.
module stripe_ptr_ctr
  import demux_pkg::*;
#(
  parameter  int unsigned LANES = DEF_LANES,
  localparam int unsigned PW    = ptr_width(LANES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          clr,
  output logic [PW-1:0] ptr,
  output logic          last
);

  logic [PW-1:0] ptr_q, ptr_d;
  logic          last_q, last_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = last_q ? '0 : ptr_q + PW'(1);
    end
    // Flag is precomputed so the top sees it as a flop, not a comparator.
    last_d = (ptr_d == PW'(LANES - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q  <= '0;
      last_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      last_q <= last_d;
    end
  end

  assign ptr  = ptr_q;
  assign last = last_q;

endmodule

// File: rtl/demux_stripe_n.sv
// Round-robin byte-striping demux: gathers LANES symbols and emits them as one bundle.
// Define DEMUX_PARTIAL_FLUSH_EN to flush a partial bundle on the first idle cycle.
module demux_stripe_n
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned LANES = DEF_LANES
) (
  input logic             clk,
  input logic             reset,
  demux_stripe_n_if.slave bus
);

  localparam int unsigned PW = ptr_width(LANES);

  logic [PW-1:0] ptr;
  logic          last;
  op_e           op;

  logic [LANES-2:0][WIDTH-1:0] staging_q, staging_d;
  logic [LANES*WIDTH-1:0]      out_q, out_d;
  logic [LANES-1:0]            validout_q, validout_d;

  always_comb begin
    op = OP_HOLD;
    if (bus.valid) begin
      op = last ? OP_EMIT : OP_ACCEPT;
    end
`ifdef DEMUX_PARTIAL_FLUSH_EN
    else if (ptr != '0) begin
      op = OP_FLUSH;
    end
`endif
  end

  stripe_ptr_ctr #(.LANES(LANES)) u_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (bus.valid),
    .clr   (op == OP_FLUSH),
    .ptr   (ptr),
    .last  (last)
  );

  always_comb begin
    staging_d = staging_q;
    if (op == OP_ACCEPT) begin
      for (int k = 0; k < int'(LANES) - 1; k++) begin
        if (ptr == PW'(k)) staging_d[k] = bus.in;
      end
    end
  end

`ifdef DEMUX_PARTIAL_FLUSH_EN
  lane_mask_t flush_mask;
  always_comb flush_mask = lane_mask(32'(ptr));
`endif

  // The final symbol of a bundle goes straight to the output, bypassing staging.
  always_comb begin
    out_d      = out_q;
    validout_d = '0;
    case (op)
      OP_EMIT: begin
        for (int k = 0; k < int'(LANES) - 1; k++) begin
          out_d[k*WIDTH +: WIDTH] = staging_q[k];
        end
        out_d[(LANES-1)*WIDTH +: WIDTH] = bus.in;
        validout_d = '1;
      end
`ifdef DEMUX_PARTIAL_FLUSH_EN
      OP_FLUSH: begin
        for (int k = 0; k < int'(LANES) - 1; k++) begin
          out_d[k*WIDTH +: WIDTH] = (PW'(k) < ptr) ? staging_q[k] : '0;
        end
        out_d[(LANES-1)*WIDTH +: WIDTH] = '0;
        validout_d = flush_mask[LANES-1:0];
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      staging_q  <= '0;
      out_q      <= '0;
      validout_q <= '0;
    end else begin
      staging_q  <= staging_d;
      out_q      <= out_d;
      validout_q <= validout_d;
    end
  end

  assign bus.out      = out_q;
  assign bus.validout = validout_q;
  assign bus.lane_ptr = ptr;

endmodule

// File: tb/tb_demux_stripe_n.sv
// Bench for demux_stripe_n: LANES=4 and LANES=3 instances share one stimulus stream.
// Reference model tracks pending symbols per instance; follows DEMUX_PARTIAL_FLUSH_EN.
module tb_demux_stripe_n;

  logic clk;
  logic reset;

  demux_stripe_n_if #(.WIDTH(8), .LANES(4)) if4 ();
  demux_stripe_n_if #(.WIDTH(8), .LANES(3)) if3 ();

  demux_stripe_n #(.WIDTH(8), .LANES(4)) dut4 (.clk(clk), .reset(reset), .bus(if4));
  demux_stripe_n #(.WIDTH(8), .LANES(3)) dut3 (.clk(clk), .reset(reset), .bus(if3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: symbols received since the last bundle, plus last expected outputs.
  int          lanes [2] = '{4, 3};
  logic [7:0]  pend  [2][4];
  int          cnt   [2];
  logic [31:0] eo    [2];
  logic [3:0]  ev    [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      cnt[i] = 0;
      eo[i]  = '0;
      ev[i]  = '0;
      for (int k = 0; k < 4; k++) pend[i][k] = '0;
    end
  endtask

  task automatic model_step(input logic v, input logic [7:0] d);
    for (int i = 0; i < 2; i++) begin
      ev[i] = '0;
      if (v) begin
        pend[i][cnt[i]] = d;
        cnt[i]++;
        if (cnt[i] == lanes[i]) begin
          eo[i] = '0;
          for (int k = 0; k < lanes[i]; k++) eo[i][k*8 +: 8] = pend[i][k];
          ev[i]  = 4'((1 << lanes[i]) - 1);
          cnt[i] = 0;
        end
      end
`ifdef DEMUX_PARTIAL_FLUSH_EN
      else if (cnt[i] > 0) begin
        eo[i] = '0;
        for (int k = 0; k < cnt[i]; k++) eo[i][k*8 +: 8] = pend[i][k];
        ev[i]  = 4'((1 << cnt[i]) - 1);
        cnt[i] = 0;
      end
`endif
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("out4",      32'(if4.out),      eo[0]);
    check("validout4", 32'(if4.validout), 32'(ev[0]));
    check("lane_ptr4", 32'(if4.lane_ptr), 32'(cnt[0]));
    check("out3",      32'(if3.out),      32'(eo[1][23:0]));
    check("validout3", 32'(if3.validout), 32'(ev[1][2:0]));
    check("lane_ptr3", 32'(if3.lane_ptr), 32'(cnt[1]));
  endtask

  // One clock: drive inputs, let the edge happen, advance model, compare.
  task automatic cycle(input logic v, input logic [7:0] d);
    if4.valid = v; if4.in = d;
    if3.valid = v; if3.in = d;
    @(posedge clk);
    model_step(v, d);
    #1;
    check_all();
  endtask

  // Reset asserted between edges must clear outputs with no clock edge.
  task automatic mid_reset();
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    if4.valid = 1'b0; if4.in = '0;
    if3.valid = 1'b0; if3.in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_all();
    check("reset_out4", 32'(if4.out), 32'h0);

    // Single bundle.
    cycle(1'b1, 8'hAA); cycle(1'b1, 8'hBB); cycle(1'b1, 8'hCC); cycle(1'b1, 8'hDD);
    check("single_out4", 32'(if4.out), 32'hDDCCBBAA);
    check("single_vo4",  32'(if4.validout), 32'hF);
    cycle(1'b0, 8'h00);
`ifndef DEMUX_PARTIAL_FLUSH_EN
    check("single_hold4", 32'(if4.out), 32'hDDCCBBAA);
`endif
    mid_reset();

    // Streaming 01..08.
    for (int s = 1; s <= 8; s++) begin
      cycle(1'b1, 8'(s));
      if (s == 4) check("stream_b0", 32'(if4.out), 32'h04030201);
      if (s == 8) check("stream_b1", 32'(if4.out), 32'h08070605);
    end
    cycle(1'b0, 8'h00);
    mid_reset();

`ifndef DEMUX_PARTIAL_FLUSH_EN
    // Gaps hold the partial bundle.
    cycle(1'b1, 8'h11); cycle(1'b0, 8'h00);
    cycle(1'b1, 8'h22); repeat (3) cycle(1'b0, 8'h00);
    cycle(1'b1, 8'h33);
    check("gap_nopulse", 32'(if4.validout), 32'h0);
    cycle(1'b1, 8'h44);
    check("gap_out4", 32'(if4.out), 32'h44332211);
`else
    cycle(1'b1, 8'h11); cycle(1'b1, 8'h22); cycle(1'b0, 8'h00);
    check("flush_out4", 32'(if4.out), 32'h00002211);
    check("flush_vo4",  32'(if4.validout), 32'h3);
`endif
    cycle(1'b0, 8'h00);

    // Reset mid-bundle discards the partial bundle.
    cycle(1'b1, 8'h55); cycle(1'b1, 8'h66);
    mid_reset();
    for (int s = 1; s <= 4; s++) begin
      cycle(1'b1, 8'(s));
      if (s == 3) check("rst_out3", 32'(if3.out), 32'h00030201);
      if (s == 4) check("rst_out4", 32'(if4.out), 32'h04030201);
    end
    check("wrap_ptr3", 32'(if3.lane_ptr), 32'h1);
    cycle(1'b0, 8'h00);

    // Randomized traffic, with one mid-run reset.
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, 8'($urandom));
      if (n == 200) mid_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
